// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator. Raster start is gated on a synchronised,
// debounced PLL lock; all outputs are registered one cycle after the counters they describe.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned LOCK_DLY  = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncFirst = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HSyncLast  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VSyncFirst = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VSyncLast  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [7:0] LockLast   = 8'(LOCK_DLY - 1);

  typedef enum logic [0:0] {StWaitLock, StRun} state_e;

  state_e     state_q, state_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       sync_q, locked_s_q;

  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       video_on_q, video_on_d;
  logic [9:0] px_x_q, px_x_d;
  logic [9:0] px_y_q, px_y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       running_q, running_d;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= StWaitLock;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      lock_cnt_q    <= '0;
      sync_q        <= 1'b0;
      locked_s_q    <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      video_on_q    <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      sync_q        <= pll_locked;
      locked_s_q    <= sync_q;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      video_on_q    <= video_on_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      StWaitLock: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (!locked_s_q) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LockLast) begin
          state_d    = StRun;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      StRun: begin
        // Losing lock abandons the frame outright; the raster restarts from 0,0.
        if (!locked_s_q) begin
          state_d    = StWaitLock;
          h_cnt_d    = '0;
          v_cnt_d    = '0;
          lock_cnt_d = '0;
        end else if (h_cnt_q == HLast) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 10'd1;
        end else begin
          h_cnt_d = h_cnt_q + 10'd1;
        end
      end
      default: state_d = StWaitLock;
    endcase
  end

  // Outputs drop to idle on the same edge that leaves RUN, not one cycle later.
  always_comb begin
    hsync_n_d     = 1'b1;
    vsync_n_d     = 1'b1;
    video_on_d    = 1'b0;
    px_x_d        = '0;
    px_y_d        = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    running_d     = 1'b0;
    if (state_q == StRun && locked_s_q) begin
      running_d     = 1'b1;
      hsync_n_d     = !(h_cnt_q >= HSyncFirst && h_cnt_q <= HSyncLast);
      vsync_n_d     = !(v_cnt_q >= VSyncFirst && v_cnt_q <= VSyncLast);
      video_on_d    = (h_cnt_q < HVis) && (v_cnt_q < VVis);
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      if (video_on_d) begin
        px_x_d = h_cnt_q;
        px_y_d = v_cnt_q;
      end
    end
  end

  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign video_on    = video_on_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus a short-frame instance (same horizontal
// timing, fewer lines) so whole-frame behaviour fits in a short run.
module tb_vga_timing_gen;

  localparam int SV_VIS  = 12;
  localparam int SV_FP   = 3;
  localparam int SV_SYNC = 2;
  localparam int SV_BP   = 4;
  localparam int SV_TOT  = SV_VIS + SV_FP + SV_SYNC + SV_BP;

  typedef struct packed {
    logic       hsync_n;
    logic       vsync_n;
    logic       video_on;
    logic [9:0] px_x;
    logic [9:0] px_y;
    logic       line_start;
    logic       frame_start;
    logic       running;
  } out_t;

  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;

  logic       hsync_n_d, vsync_n_d, video_on_d, line_start_d, frame_start_d, running_d;
  logic [9:0] px_x_d, px_y_d;
  logic       hsync_n_s, vsync_n_s, video_on_s, line_start_s, frame_start_s, running_s;
  logic [9:0] px_x_s, px_y_s;

  always #20 refclk = ~refclk;

  vga_timing_gen dut_d (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .hsync_n    (hsync_n_d),
    .vsync_n    (vsync_n_d),
    .video_on   (video_on_d),
    .px_x       (px_x_d),
    .px_y       (px_y_d),
    .line_start (line_start_d),
    .frame_start(frame_start_d),
    .running    (running_d)
  );

  vga_timing_gen #(
    .V_VISIBLE(SV_VIS),
    .V_FP     (SV_FP),
    .V_SYNC   (SV_SYNC),
    .V_BP     (SV_BP)
  ) dut_s (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .hsync_n    (hsync_n_s),
    .vsync_n    (vsync_n_s),
    .video_on   (video_on_s),
    .px_x       (px_x_s),
    .px_y       (px_y_s),
    .line_start (line_start_s),
    .frame_start(frame_start_s),
    .running    (running_s)
  );

  out_t act_d, act_s;
  assign act_d = {hsync_n_d, vsync_n_d, video_on_d, px_x_d, px_y_d, line_start_d,
                  frame_start_d, running_d};
  assign act_s = {hsync_n_s, vsync_n_s, video_on_s, px_x_s, px_y_s, line_start_s,
                  frame_start_s, running_s};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic out_t idle_out();
    out_t o;
    o = '0;
    o.hsync_n = 1'b1;
    o.vsync_n = 1'b1;
    return o;
  endfunction

  // Outputs for a raster that has been running for t cycles since it left WAIT_LOCK.
  function automatic out_t decode(int t, int vtot, int vvis, int vsync_first);
    out_t o;
    int h, v;
    h = t % 800;
    v = (t / 800) % vtot;
    o = idle_out();
    o.running     = 1'b1;
    o.hsync_n     = !(h >= 656 && h <= 751);
    o.vsync_n     = !(v >= vsync_first && v <= vsync_first + 1);
    o.video_on    = (h < 640) && (v < vvis);
    o.line_start  = (h == 0);
    o.frame_start = (h == 0) && (v == 0);
    if (o.video_on) begin
      o.px_x = 10'(h);
      o.px_y = 10'(v);
    end
    return o;
  endfunction

  // Behavioural model: lock seen two edges late, raster time counted as elapsed cycles.
  bit   m_valid = 1'b0;
  bit   m_run, m_s1, m_s2, m_ls;
  int   m_t, m_streak;
  out_t exp_d, exp_s;

  always @(posedge refclk) begin
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_streak = 0; m_s1 = 1'b0; m_s2 = 1'b0;
      exp_d = idle_out();
      exp_s = idle_out();
    end else begin
      m_ls = m_s2;
      if (m_run && m_ls) begin
        exp_d = decode(m_t, 525, 480, 490);
        exp_s = decode(m_t, SV_TOT, SV_VIS, SV_VIS + SV_FP);
      end else begin
        exp_d = idle_out();
        exp_s = idle_out();
      end
      if (m_run) begin
        if (m_ls) m_t++;
        else begin
          m_run = 1'b0; m_streak = 0;
        end
      end else if (m_ls) begin
        if (m_streak == 15) begin
          m_run = 1'b1; m_t = 0; m_streak = 0;
        end else m_streak++;
      end else m_streak = 0;
      m_s2 = m_s1;
      m_s1 = pll_locked;
    end
    m_valid = 1'b1;
  end

  always @(negedge refclk) begin
    if (m_valid) begin
      n_cmp++;
      if (act_d !== exp_d) begin
        n_bad++;
        $display("FAIL model_full t=%0t got=%h want=%h", $time, act_d, exp_d);
      end
      n_cmp++;
      if (act_s !== exp_s) begin
        n_bad++;
        $display("FAIL model_short t=%0t got=%h want=%h", $time, act_s, exp_s);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic count_to_fs(input int limit, output int n);
    n = 0;
    do begin
      @(negedge refclk);
      n++;
    end while (!frame_start_d && n < limit);
  endtask

  initial begin
    int   n, c, hs_first, hs_cnt, vo_cnt, px_bad, ls_next;
    int   vs_first, vs_cnt, vo_late, fs_next;
    out_t o;

    // Pin the reference decode to hand-computed points.
    o = decode(0, 525, 480, 490);
    check("model_origin_fs", int'(o.frame_start), 1);
    o = decode(656, 525, 480, 490);
    check("model_hsync_first", int'(o.hsync_n), 0);
    o = decode(490 * 800 + 5, 525, 480, 490);
    check("model_vsync_line490", int'(o.vsync_n), 0);
    o = decode(479 * 800 + 639, 525, 480, 490);
    check("model_last_px", int'(o.px_x) * 1000 + int'(o.px_y), 639479);

    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (4) @(negedge refclk);
    check("reset_hsync_n", int'(hsync_n_d), 1);
    check("reset_running", int'(running_d), 0);

    // Startup with lock present from release.
    rst = 1'b0;
    pll_locked = 1'b1;
    count_to_fs(40, n);
    check("startup_latency", n, 19);
    check("startup_px", int'(px_x_d) + int'(px_y_d), 0);
    check("startup_video_on", int'(video_on_d), 1);
    check("startup_running", int'(running_d), 1);

    // One-cycle lock glitch during the settle count.
    rst = 1'b1;
    repeat (2) @(negedge refclk);
    rst = 1'b0;
    pll_locked = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge refclk);
      n++;
    end
    pll_locked = 1'b0;
    @(negedge refclk);
    n++;
    pll_locked = 1'b1;
    do begin
      @(negedge refclk);
      n++;
    end while (!frame_start_d && n < 60);
    check("glitch_latency", n, 30);

    // Line 0 of the full-size raster.
    hs_first = -1; hs_cnt = 0; vo_cnt = 0; px_bad = 0; ls_next = -1;
    for (int i = 0; i <= 800; i++) begin
      if (i > 0) @(negedge refclk);
      if (i > 0 && line_start_d && ls_next < 0) ls_next = i;
      if (i < 800) begin
        if (!hsync_n_d) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = i;
        end
        if (video_on_d) begin
          vo_cnt++;
          if (int'(px_x_d) != i) px_bad++;
        end
      end
    end
    check("line_period", ls_next, 800);
    check("hsync_start", hs_first, 656);
    check("hsync_len", hs_cnt, 96);
    check("visible_len", vo_cnt, 640);
    check("px_x_steps", px_bad, 0);

    // Rest of the short frame.
    c = 800; vs_first = -1; vs_cnt = 0; vo_late = 0; fs_next = -1;
    while (fs_next < 0 && c < 20000) begin
      @(negedge refclk);
      c++;
      if (frame_start_s) fs_next = c;
      else begin
        if (!vsync_n_s) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = c;
        end
        if (video_on_s && c / 800 >= SV_VIS) vo_late++;
      end
    end
    check("frame_period", fs_next, SV_TOT * 800);
    check("vsync_start", vs_first, (SV_VIS + SV_FP) * 800);
    check("vsync_len", vs_cnt, 1600);
    check("blank_rows_dark", vo_late, 0);

    // Lock loss mid-frame.
    n = 0;
    while (!(video_on_s && px_y_s == 10'd10 && px_x_s == 10'd300) && n < 20000) begin
      @(negedge refclk);
      n++;
    end
    check("lockloss_reach", n, 10 * 800 + 300);
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    check("lockloss_still_running", int'(running_s), 1);
    @(negedge refclk);
    check("lockloss_idle_short", int'(act_s), int'(idle_out()));
    check("lockloss_idle_full", int'(act_d), int'(idle_out()));
    repeat ($urandom_range(3, 20)) @(negedge refclk);
    pll_locked = 1'b1;
    count_to_fs(60, n);
    check("relock_latency", n, 19);
    check("relock_px", int'(px_x_s) + int'(px_y_s), 0);

    // Reset pulse during hsync.
    n = 0;
    while (hsync_n_d && n < 1000) begin
      @(negedge refclk);
      n++;
    end
    check("reach_hsync", int'(hsync_n_d), 0);
    rst = 1'b1;
    @(negedge refclk);
    check("rst_hsync_n", int'(hsync_n_d), 1);
    check("rst_running", int'(running_d), 0);
    rst = 1'b0;
    count_to_fs(60, n);
    check("rst_restart_latency", n, 19);
    repeat (2000) @(negedge refclk);

    // Random disturbances, checked by the model every cycle.
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(50, 1500)) @(negedge refclk);
      case ($urandom_range(0, 2))
        0: begin
          pll_locked = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge refclk);
          pll_locked = 1'b1;
        end
        1: begin
          rst = 1'b1;
          @(negedge refclk);
          rst = 1'b0;
        end
        default: ;
      endcase
    end
    repeat (200) @(negedge refclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25.175 MHz pixel clock produced by the upstream PLL (`outclk_0`).
- Gates raster start on the PLL `locked` output, which arrives asynchronously: it is synchronised, then debounced for a fixed settle time.
- Drives active-low hsync/vsync, a video-enable flag and pixel coordinates to the downstream pixel/colour stage and the VGA DAC pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- LOCK_DLY, 16, consecutive synchronised-locked cycles required before raster start (1..255)

Ports:
- refclk  in  1  pixel clock, 25.175 MHz, driven from PLL outclk_0
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  PLL locked flag, asynchronous to refclk
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- video_on  out  1  high while the current pixel is in the visible region
- px_x  out  10  visible column 0..639; 0 when not visible
- px_y  out  10  visible row 0..479; 0 when not visible
- line_start  out  1  one-cycle pulse at h_cnt==0 of every line
- frame_start  out  1  one-cycle pulse at h_cnt==0, v_cnt==0
- running  out  1  high in RUN state

Behaviour:
- Derived constants: H_TOTAL = 800, V_TOTAL = 525.
- Reset values, all registered outputs:
  - hsync_n=1, vsync_n=1
  - video_on=0, px_x=0, px_y=0
  - line_start=0, frame_start=0, running=0
  - state=WAIT_LOCK, h_cnt=0, v_cnt=0, lock_cnt=0
- Lock synchroniser: two flops on pll_locked giving locked_s (2-cycle latency); both flops reset to 0.
- State WAIT_LOCK:
  - If locked_s=1, lock_cnt increments; if locked_s=0, lock_cnt clears.
  - When lock_cnt==LOCK_DLY-1 and locked_s=1, go to RUN with h_cnt=0, v_cnt=0.
  - Outputs stay at their reset values while in this state.
- State RUN:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - On each h wrap, v_cnt counts 0..V_TOTAL-1, then wraps to 0.
  - The 799->0 and 524->0 transitions happen in the same cycle.
  - If locked_s=0 in any RUN cycle, the next state is WAIT_LOCK: h_cnt, v_cnt and lock_cnt clear, and all outputs return to reset values on the next edge. There is no partial-frame completion.
- Output decode: registered, one cycle after the counter value it describes.
  - hsync_n=0 iff 656 <= h_cnt <= 751.
  - vsync_n=0 iff 490 <= v_cnt <= 491; hsync continues to toggle during vsync.
  - video_on=1 iff h_cnt<640 and v_cnt<480.
  - px_x=h_cnt and px_y=v_cnt when video_on, else 0.
  - line_start=1 iff h_cnt==0; frame_start=1 iff h_cnt==0 and v_cnt==0.
  - running=1 for every cycle whose decoded counter came from RUN.
- rst overrides everything, including during RUN and mid-lock-count.
- Counter widths: h_cnt and v_cnt are 10 bits; lock_cnt is 8 bits. No overflow is possible within the parameter limits.

Test Plan:
- Startup:
  - Stimulus: rst high 4 cycles, pll_locked=1 from release.
  - Required response: first frame_start=1 and running=1 exactly 2+16+1 = 19 cycles after rst deassertion.
  - Required response: px_x=0, px_y=0, video_on=1 in that same cycle.
- Lock glitch in WAIT_LOCK:
  - Stimulus: pll_locked high 10 cycles, low 1 cycle, high again.
  - Required response: lock_cnt restarts; raster starts 16 cycles after the synchronised re-rise, not earlier.
- Line timing:
  - In RUN, check the line period: line_start pulses every 800 cycles.
  - Check the hsync window: hsync_n low for exactly 96 cycles, beginning 656 cycles after line_start.
  - Check the visible window: video_on high for 640 cycles per visible line, and px_x steps 0..639.
- Frame timing:
  - Check the frame period: frame_start pulses every 420000 cycles.
  - Check the vsync window: vsync_n low for exactly 1600 cycles, starting 490*800 cycles after frame_start.
  - Check the visible rows: video_on never high on lines 480..524.
- Lock loss mid-frame:
  - Stimulus: drop pll_locked at line 200, pixel 300.
  - Required response: within 3 cycles all outputs are at reset values and running=0.
  - Stimulus: re-assert pll_locked.
  - Required response: frame restarts at px 0,0 with frame_start after 2+16+1 cycles.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during hsync, pll_locked held high.
  - Required response: next cycle hsync_n=1, running=0.
  - Required response: a fresh 19-cycle startup follows, then a normal frame.
